// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   rx_state_t  - receiver FSM state encoding
//   OS_MID      - oversample index at the middle of the start bit
//   OS_LAST     - oversample index at the middle of data/stop bits
//   DATA_BITS   - data bits per frame (8N1)
//   os_divider  - clk cycles per 16x oversample tick for a given clock/baud
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam logic [3:0] OS_MID    = 4'd7;
    localparam logic [3:0] OS_LAST   = 4'd15;
    localparam int         DATA_BITS = 8;
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    // Never returns less than 1 so a very fast baud still yields a legal divider.
    function automatic int os_divider(input int clock_rate, input int baud_rate);
        int div;
        div = clock_rate / (16 * baud_rate);
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversample enable generator.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous, active-high reset
//   en   out one-clk pulse, 16 pulses per bit period
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = 57_600,
    parameter int CLOCK_RATE = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic en
);

    localparam int DIV = os_divider(CLOCK_RATE, BAUD_RATE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            en  <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            en  <= 1'b1;
        end else begin
            cnt <= cnt + CW'(1);
            en  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with 16x oversampling.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   rxd_i        in   asynchronous serial input, idle high
//   rx_data      out  last good byte, held until the next good frame
//   rx_data_rdy  out  one-clk strobe, rx_data updated this cycle
//   frm_err      out  one-clk strobe, stop bit sampled low
//   rx_busy      out  high whenever the FSM is not in IDLE
//
// Output semantics: rx_data_rdy is a valid strobe with no ready/backpressure.
// The byte on rx_data is valid on the cycle rx_data_rdy is high and stays
// stable until the next good frame; a consumer that misses it within one byte
// time loses it. frm_err and rx_data_rdy are mutually exclusive.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = 57_600,
    parameter int CLOCK_RATE = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd_i,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       frm_err,
    output logic       rx_busy
);

    logic en;

    uart_baud_gen #(
        .BAUD_RATE (BAUD_RATE),
        .CLOCK_RATE(CLOCK_RATE)
    ) u_baud_gen (
        .clk(clk),
        .rst(rst),
        .en (en)
    );

    // Two-flop synchroniser; resets to the idle level so reset never looks
    // like a start edge.
    logic meta;
    logic rxd_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            meta  <= rxd_i;
            rxd_s <= meta;
        end
    end

    rx_state_t  state, state_next;
    logic [3:0] os_cnt, os_cnt_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] sh, sh_next;
    logic [7:0] data_next;
    logic       rdy_next;
    logic       err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        os_cnt_next  = os_cnt;
        bit_cnt_next = bit_cnt;
        sh_next      = sh;
        data_next    = rx_data;
        rdy_next     = 1'b0;
        err_next     = 1'b0;

        if (en) begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_next  = START;
                        os_cnt_next = 4'd0;
                    end
                end
                START: begin
                    if (os_cnt == OS_MID) begin
                        // A line back high at mid start bit was a glitch.
                        if (!rxd_s) begin
                            state_next   = DATA;
                            os_cnt_next  = 4'd0;
                            bit_cnt_next = 3'd0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        os_cnt_next = os_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (os_cnt == OS_LAST) begin
                        sh_next     = {rxd_s, sh[7:1]};
                        os_cnt_next = 4'd0;
                        if (bit_cnt == BIT_LAST) begin
                            state_next = STOP;
                        end else begin
                            bit_cnt_next = bit_cnt + 3'd1;
                        end
                    end else begin
                        os_cnt_next = os_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt_next = 4'd0;
                        if (rxd_s) begin
                            data_next  = sh;
                            rdy_next   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            err_next   = 1'b1;
                            state_next = WAIT_HIGH;
                        end
                    end else begin
                        os_cnt_next = os_cnt + 4'd1;
                    end
                end
                WAIT_HIGH: begin
                    // A break holds the line low; wait for idle before rearming.
                    if (rxd_s) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt      <= 4'd0;
            bit_cnt     <= 3'd0;
            sh          <= 8'h00;
            rx_data     <= 8'h00;
            rx_data_rdy <= 1'b0;
            frm_err     <= 1'b0;
        end else begin
            os_cnt      <= os_cnt_next;
            bit_cnt     <= bit_cnt_next;
            sh          <= sh_next;
            rx_data     <= data_next;
            rx_data_rdy <= rdy_next;
            frm_err     <= err_next;
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at 32 clk per bit.
module tb_uart_rx_frame;

    localparam int BIT_CLKS = 32;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd_i = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       frm_err;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_rx_frame #(
        .BAUD_RATE (50_000),
        .CLOCK_RATE(1_600_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd_i      (rxd_i),
        .rx_data    (rx_data),
        .rx_data_rdy(rx_data_rdy),
        .frm_err    (frm_err),
        .rx_busy    (rx_busy)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int checks   = 0;
    int errors   = 0;
    int rdy_seen = 0;
    int err_seen = 0;
    int exp_rdy  = 0;
    int exp_err  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic v, input int n);
        rxd_i = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_q.push_back(b);
            exp_rdy++;
        end else begin
            exp_err++;
        end
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i], BIT_CLKS);
        end
        drive_bit(stop_ok, BIT_CLKS);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_data_rdy && frm_err) begin
                checks++;
                errors++;
                $display("FAIL strobe_exclusive: rdy=%0b err=%0b, expected not both", rx_data_rdy, frm_err);
            end
            if (rx_data_rdy) begin
                rdy_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: got data %0h, expected no strobe", rx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL rx_data: got %0h, expected %0h", rx_data, e);
                    end
                    last_good = e;
                end
            end
            if (frm_err) begin
                err_seen++;
                checks++;
                if (rx_data !== last_good) begin
                    errors++;
                    $display("FAIL frm_err_data_held: got %0h, expected %0h", rx_data, last_good);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] c3 = 8'hC3;

    initial begin
        repeat (4) @(negedge clk);
        check("reset_rx_data", {24'h0, rx_data}, 32'h00);
        check("reset_rdy", {31'h0, rx_data_rdy}, 32'h0);
        check("reset_frm_err", {31'h0, frm_err}, 32'h0);
        check("reset_busy", {31'h0, rx_busy}, 32'h0);
        rst = 1'b0;
        drive_bit(1'b1, 64);

        // Single good frame.
        send_byte(8'hA5, 1'b1);
        drive_bit(1'b1, 4);
        check("a5_busy_after", {31'h0, rx_busy}, 32'h0);
        check("a5_rdy_count", rdy_seen, exp_rdy);
        check("a5_err_count", err_seen, 0);
        check("a5_queue_empty", exp_q.size(), 0);

        // Back-to-back frames, zero idle gap.
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        drive_bit(1'b1, 4);
        check("b2b_rdy_count", rdy_seen, exp_rdy);
        check("b2b_queue_empty", exp_q.size(), 0);

        // Short low glitch on an idle line.
        drive_bit(1'b0, 10);
        drive_bit(1'b1, 40);
        check("glitch_busy", {31'h0, rx_busy}, 32'h0);
        check("glitch_rdy_count", rdy_seen, exp_rdy);
        check("glitch_err_count", err_seen, 0);

        // Framing error followed by a held-low line.
        send_byte(8'h3C, 1'b0);
        drive_bit(1'b0, 3 * BIT_CLKS);
        check("ferr_err_count", err_seen, 1);
        check("ferr_busy_while_low", {31'h0, rx_busy}, 32'h1);
        check("ferr_rdy_count", rdy_seen, exp_rdy);
        check("ferr_data_held", {24'h0, rx_data}, 32'hFF);
        drive_bit(1'b1, 8);
        check("ferr_busy_after_high", {31'h0, rx_busy}, 32'h0);
        send_byte(8'h5A, 1'b1);
        drive_bit(1'b1, 4);
        check("post_ferr_rdy_count", rdy_seen, exp_rdy);

        // Reset pulse during bit 4 of 0xC3; the frame is abandoned.
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            drive_bit(c3[i], BIT_CLKS);
        end
        drive_bit(c3[4], BIT_CLKS / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        check("midrst_rx_data", {24'h0, rx_data}, 32'h00);
        check("midrst_rdy", {31'h0, rx_data_rdy}, 32'h0);
        check("midrst_frm_err", {31'h0, frm_err}, 32'h0);
        check("midrst_busy", {31'h0, rx_busy}, 32'h0);
        drive_bit(1'b1, 3 * BIT_CLKS);
        check("midrst_rdy_count", rdy_seen, exp_rdy);
        check("midrst_err_count", err_seen, exp_err);
        send_byte(8'h81, 1'b1);
        drive_bit(1'b1, 4);
        check("post_rst_rdy_count", rdy_seen, exp_rdy);

        // All byte values with random idle gaps.
        for (int v = 0; v < 256; v++) begin
            send_byte(v[7:0], 1'b1);
            drive_bit(1'b1, $urandom_range(0, 40));
        end

        for (int t = 0; t < 400 && exp_q.size() != 0; t++) begin
            @(negedge clk);
        end
        check("final_queue_drained", exp_q.size(), 0);
        check("final_rdy_count", rdy_seen, exp_rdy);
        check("final_err_count", err_seen, exp_err);
        check("final_busy", {31'h0, rx_busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- 8N1 UART receiver; sits directly downstream of uart_baud_gen and consumes its 16x oversample enable.
- Synchronises the asynchronous serial input and detects and validates the start bit at mid-bit.
- Shifts in 8 data bits LSB first and checks the stop bit.
- Presents each received byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
- BAUD_RATE, 57_600: serial bit rate; passed to the uart_baud_gen instance.
- CLOCK_RATE, 50_000_000: clk frequency in Hz; passed to the uart_baud_gen instance.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; clock clk
- rxd_i  in  1  serial input, asynchronous to clk, idle high
- rx_data  out  8  last good received byte; held until the next good frame
- rx_data_rdy  out  1  one-clk strobe: rx_data updated this cycle
- frm_err  out  1  one-clk strobe: stop bit sampled low
- rx_busy  out  1  high whenever state != IDLE

Behaviour:
- Synchroniser: two flops, rxd_i -> meta -> rxd_s; both reset to 1. All decisions use rxd_s only.
- Oversample enable (en): from the internal uart_baud_gen instance. Every counter below advances only on cycles where en=1.
- Counters: os_cnt[3:0] oversample counter; bit_cnt[2:0] data bit index; shift register sh[7:0].
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - en and rxd_s=0 -> START, os_cnt=0.
- START: os_cnt increments per en. At the en where os_cnt=7 (mid start bit):
  - rxd_s=0 -> DATA, os_cnt=0, bit_cnt=0.
  - rxd_s=1 -> IDLE (glitch rejected, no output strobe).
- DATA: os_cnt increments per en. At the en where os_cnt=15 (mid data bit):
  - sh <= {rxd_s, sh[7:1]} (LSB first).
  - os_cnt wraps to 0.
  - bit_cnt=7 -> STOP; otherwise bit_cnt+1.
- STOP: at the en where os_cnt=15 (mid stop bit):
  - rxd_s=1: rx_data<=sh, rx_data_rdy=1 next cycle, -> IDLE.
  - rxd_s=0: frm_err=1 next cycle, rx_data unchanged, -> WAIT_HIGH.
- WAIT_HIGH:
  - en and rxd_s=1 -> IDLE.
  - A held-low line (break) never retriggers a start.
- Output register behaviour:
  - rx_data_rdy and frm_err are registered; each is high for exactly one clk per frame; they are never both high.
- Latency:
  - rx_data_rdy asserts 1 clk after the mid-stop en.
  - Total is about 9.5 bit periods after the start falling edge, plus 2-3 clks of synchronisation.
- Back-to-back frames: a start edge arriving immediately after the mid-stop sample is accepted; IDLE checks on the very next en.
- Reset values:
  - rx_data=8'h00, rx_data_rdy=0, frm_err=0, rx_busy=0.
  - State=IDLE; os_cnt, bit_cnt and sh all 0; sync flops=1.
- Reset mid-frame:
  - Abandons the frame with no strobe.
  - The receiver resumes start detection only after rst deasserts and the line has resynchronised.
- No flow control: the consumer must take rx_data within one byte time; the next good frame overwrites it without notice.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, DATA, STOP, WAIT_HIGH).
  - Constants OS_MID=7, OS_LAST=15, DATA_BITS=8.
- Sub-module: the existing uart_baud_gen, instantiated inside with BAUD_RATE and CLOCK_RATE forwarded.
- Synchroniser: inline two-flop logic; no separate module.

Test Plan (sim parameters CLOCK_RATE=1_600_000, BAUD_RATE=50_000 -> divider 2, 1 bit = 32 clk):
- Send byte 8'hA5 with a good stop bit -> one rx_data_rdy pulse, rx_data=8'hA5, frm_err never high, rx_busy low after the frame.
- Send 8'h00 then 8'hFF back-to-back, zero idle gap -> two rdy pulses, values 00 then FF, in order.
- 10-clk low glitch on idle line (shorter than half a bit) -> START returns to IDLE; no rdy, no frm_err.
- Byte 8'h3C with stop bit low, line then held low for 3 bit times -> one frm_err pulse, rx_data keeps previous value, no new frame until line high; next good 8'h5A received correctly.
- Assert rst for 1 clk during bit 4 of 8'hC3 -> no strobe; all outputs at reset values; a following 8'h81 is received correctly.
- Sweep all 256 byte values with random 0-40 clk idle gaps -> each byte received exactly once, matching sent data.
